uart_fifo_tx: RTL and testbench

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_fifo_tx.sv | 124 ++++++++++++
 tb/tb_uart_fifo_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam int unsigned DEFAULT_DATA_WIDTH   = 8;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses on the last count.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_restart,
   output logic o_tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_count;

   assign o_tick = i_en && (r_count == LAST_CNT);

   // Cleared at every bit boundary so the counter never wraps on its own.
   always_ff @(posedge clk) begin
      if (!rst_n || i_restart || !i_en || o_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter fed from a first-word-fall-through FIFO; frames are sent back to back.
module uart_fifo_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty_i,
   output logic                  fifo_rden_o,
   input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   tx_state_t             r_state;
   tx_state_t             w_state_nxt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [IDX_W-1:0]      r_bit_idx;
   logic                  r_tx;
   logic                  w_tick;
   logic                  w_pop;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (r_state != ST_IDLE),
      .i_restart(w_pop),
      .o_tick   (w_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!fifo_empty_i) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (w_tick) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (w_tick && (r_bit_idx == LAST_IDX)) w_state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (w_tick) begin
               if (!fifo_empty_i) begin
                  w_pop       = 1'b1;
                  w_state_nxt = ST_START;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // No pop may be issued while reset is held; the byte would be lost.
      if (!rst_n) w_pop = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_tx      <= 1'b1;
      end else if (w_pop) begin
         r_shift   <= fifo_rdata_i;
         r_bit_idx <= '0;
         r_tx      <= 1'b0;
      end else if (w_tick) begin
         case (r_state)
            ST_START: begin
               r_tx      <= r_shift[0];
               r_shift   <= r_shift >> 1;
               r_bit_idx <= '0;
            end
            ST_DATA: begin
               if (r_bit_idx == LAST_IDX) begin
                  r_tx <= 1'b1;
               end else begin
                  r_tx      <= r_shift[0];
                  r_shift   <= r_shift >> 1;
                  r_bit_idx <= r_bit_idx + IDX_W'(1);
               end
            end
            default: r_tx <= 1'b1;
         endcase
      end
   end

   assign tx_o        = r_tx;
   assign busy_o      = (r_state != ST_IDLE);
   assign done_o      = (r_state == ST_STOP) && w_tick;
   assign fifo_rden_o = w_pop;

   always_ff @(posedge clk) begin
      if (rst_n && fifo_rden_o) begin
         assert (!fifo_empty_i) else $error("uart_fifo_tx: pop issued while FIFO empty");
      end
   end

   if (CLKS_PER_BIT < 2) begin : g_bad_cfg
      $error("uart_fifo_tx: CLKS_PER_BIT must be at least 2");
   end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed and random checks of uart_fifo_tx against a frame-level model with a queue-backed FIFO.
module tb_uart_fifo_tx;

   localparam int DW    = 8;
   localparam int CPB   = 4;
   localparam int FRAME = (DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_empty_i = 1'b1;
   logic          fifo_rden_o;
   logic [DW-1:0] fifo_rdata_i = '0;
   logic          tx_o;
   logic          busy_o;
   logic          done_o;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] sent[$];
   int            k = 0;
   logic [DW-1:0] cur = '0;
   int            cyc = 0;
   int            dut_pops = 0;
   int            dut_dones = 0;
   int            dut_pop_cyc[$];
   int            dut_done_cyc[$];

   always #5 clk = ~clk;

   uart_fifo_tx #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fifo_empty_i(fifo_empty_i),
      .fifo_rden_o (fifo_rden_o),
      .fifo_rdata_i(fifo_rdata_i),
      .tx_o        (tx_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   // Line level k cycles after a pop: slot 0 start, slots 1..DW data LSB first, then stop.
   function automatic logic exp_tx();
      int slot;
      if (k == 0) return 1'b1;
      slot = (k - 1) / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= DW) return cur[slot-1];
      return 1'b1;
   endfunction

   task automatic update_inputs();
      fifo_empty_i = (q.size() == 0);
      fifo_rdata_i = (q.size() != 0) ? q[0] : DW'($urandom);
   endtask

   task automatic cycle();
      logic exp_pop;
      @(negedge clk);
      exp_pop = rst_n && (q.size() != 0) && ((k == 0) || (k == FRAME));
      check("tx",   tx_o,        exp_tx());
      check("busy", busy_o,      (k != 0));
      check("done", done_o,      (k == FRAME));
      check("rden", fifo_rden_o, exp_pop);
      if (fifo_rden_o === 1'b1) begin
         dut_pops++;
         dut_pop_cyc.push_back(cyc);
      end
      if (done_o === 1'b1) begin
         dut_dones++;
         dut_done_cyc.push_back(cyc);
      end
      @(posedge clk);
      if (!rst_n) begin
         k = 0;
      end else if (exp_pop) begin
         k   = 1;
         cur = q.pop_front();
         sent.push_back(cur);
      end else if (k == FRAME) begin
         k = 0;
      end else if (k != 0) begin
         k++;
      end
      cyc++;
      #1 update_inputs();
   endtask

   initial begin
      int p0;
      int d0;
      int guard;

      // Reset held with a non-empty FIFO: no pop, line idle.
      rst_n = 1'b0;
      q.push_back(8'h5A);
      update_inputs();
      repeat (3) cycle();
      q.delete();
      update_inputs();
      rst_n = 1'b1;
      repeat (5) cycle();

      // Single byte 0xA5.
      p0 = dut_pops;
      d0 = dut_dones;
      q.push_back(8'hA5);
      update_inputs();
      repeat (FRAME + 5) cycle();
      check_int("a5_pops", dut_pops - p0, 1);
      check_int("a5_dones", dut_dones - d0, 1);
      check_int("a5_done_offset", dut_done_cyc[$] - dut_pop_cyc[$], FRAME);

      // Back-to-back 0x00, 0xFF.
      p0 = dut_pops;
      q.push_back(8'h00);
      q.push_back(8'hFF);
      update_inputs();
      repeat (2 * FRAME + 5) cycle();
      check_int("b2b_pops", dut_pops - p0, 2);
      check_int("b2b_spacing", dut_pop_cyc[$] - dut_pop_cyc[$-1], FRAME);

      // Empty FIFO for 100 cycles.
      p0 = dut_pops;
      repeat (100) cycle();
      check_int("idle_pops", dut_pops - p0, 0);

      // Reset during data bit 3 of 0x3C, then 0x81 waiting after release.
      p0 = dut_pops;
      q.push_back(8'h3C);
      update_inputs();
      guard = 0;
      while (k != 18 && guard < 200) begin
         cycle();
         guard++;
      end
      check_int("reach_bit3", (guard < 200) ? 1 : 0, 1);
      rst_n = 1'b0;
      q.push_back(8'h81);
      update_inputs();
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (FRAME + 5) cycle();
      check_int("rst_pops", dut_pops - p0, 2);
      check_int("rst_fifo_left", q.size(), 0);
      check_int("rst_last_byte", int'(sent[$]), 8'h81);

      // Sixteen random bytes queued at once.
      p0 = dut_pops;
      d0 = dut_dones;
      for (int i = 0; i < 16; i++) q.push_back(DW'($urandom));
      update_inputs();
      repeat (16 * FRAME + 5) cycle();
      check_int("burst_pops", dut_pops - p0, 16);
      check_int("burst_dones", dut_dones - d0, 16);
      check_int("burst_fifo_left", q.size(), 0);
      check_int("burst_spacing", dut_pop_cyc[$] - dut_pop_cyc[$-15], 15 * FRAME);

      // Random trickle of bytes with arbitrary gaps.
      p0 = dut_pops;
      d0 = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            q.push_back(DW'($urandom));
            d0++;
         end
         update_inputs();
         cycle();
      end
      repeat (FRAME * 4) cycle();
      check_int("trickle_fifo_left", q.size(), 0);
      check_int("trickle_pops", dut_pops - p0, d0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
